// File: rtl/icache_pkg.sv
// Shared types and geometry for the instruction-cache refill path.
// Default geometry: 64-byte lines, 8 ways, 64-bit memory beats.
package icache_pkg;

  localparam int CFG_LINE_SIZE = 64;
  localparam int CFG_WAYS      = 8;
  localparam int CFG_MEM_WIDTH = 64;

  localparam int BEATS      = CFG_LINE_SIZE * 8 / CFG_MEM_WIDTH;
  localparam int BEAT_CNT_W = $clog2(BEATS);
  localparam int OFFSET_W   = $clog2(CFG_LINE_SIZE);
  localparam int WAY_W      = $clog2(CFG_WAYS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_FILL,
    S_UPDATE,
    S_DRAIN
  } state_e;

  function automatic logic [31:0] line_base(input logic [31:0] addr, input int unsigned line_size);
    return addr & ~(line_size[31:0] - 32'd1);
  endfunction

endpackage

// File: rtl/icache_line_assembler.sv
// Beat counter plus line buffer: each accepted beat lands at slot cnt, then cnt advances.
// store_i low still advances the counter, so aborted refills can drain without touching the buffer.
module icache_line_assembler
  import icache_pkg::*;
#(
  parameter int MEM_WIDTH = CFG_MEM_WIDTH,
  parameter int NBEATS    = BEATS,
  parameter int CNT_W     = BEAT_CNT_W
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr_i,
  input  logic                        beat_vld_i,
  input  logic                        store_i,
  input  logic [MEM_WIDTH-1:0]        beat_dat_i,
  output logic [CNT_W-1:0]            cnt_o,
  output logic                        last_o,
  output logic [NBEATS*MEM_WIDTH-1:0] line_o
);

  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [NBEATS*MEM_WIDTH-1:0] line_q, line_d;

  always_comb begin
    cnt_d  = cnt_q;
    line_d = line_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (beat_vld_i) begin
      cnt_d = cnt_q + 1'b1;
      if (store_i) line_d[cnt_q*MEM_WIDTH +: MEM_WIDTH] = beat_dat_i;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      line_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      line_q <= line_d;
    end
  end

  assign cnt_o  = cnt_q;
  assign last_o = (cnt_q == CNT_W'(NBEATS - 1));
  assign line_o = line_q;

endmodule

// File: rtl/icache_refill_controller.sv
// Miss handler: stalls fetch, issues a line burst read, assembles beats, installs the line
// into a round-robin way. Flush aborts; an accepted burst is always drained to completion.
module icache_refill_controller
  import icache_pkg::*;
#(
  parameter int LINE_SIZE = CFG_LINE_SIZE,
  parameter int WAYS      = CFG_WAYS,
  parameter int MEM_WIDTH = CFG_MEM_WIDTH
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              flush,
  input  logic                              query_valid,
  input  logic [31:0]                       query_addr,
  input  logic                              query_hit,
  output logic                              miss_stall,
  output logic                              mem_req_valid,
  input  logic                              mem_req_ready,
  output logic [31:0]                       mem_req_addr,
  output logic [7:0]                        mem_req_len,
  input  logic                              mem_rvalid,
  input  logic [MEM_WIDTH-1:0]              mem_rdata,
  input  logic                              mem_rlast,
  output logic                              do_update_line,
  output logic                              do_update_tag_and_valid,
  output logic                              do_clear_dirty,
  output logic [31:0]                       update_addr,
  output logic [LINE_SIZE*8-1:0]            update_line_data,
  output logic [$clog2(WAYS)-1:0]           update_way,
  output logic                              update_dirty_bit,
  output logic                              refill_done,
  output logic                              refill_err
);

  localparam int NBEATS   = LINE_SIZE * 8 / MEM_WIDTH;
  localparam int CNT_W    = $clog2(NBEATS);
  localparam int WAY_BITS = $clog2(WAYS);

  state_e                state_q, state_d;
  logic [31:0]           miss_addr_q, miss_addr_d;
  logic [WAY_BITS-1:0]   rr_q, rr_d;
  logic                  err_q, err_d;
  logic                  asm_clr, asm_vld, asm_store, asm_last;
  logic [CNT_W-1:0]      asm_cnt;
  logic                  miss;

  assign miss = query_valid & ~query_hit & ~flush;

  always_comb begin
    state_d                 = state_q;
    miss_addr_d             = miss_addr_q;
    rr_d                    = rr_q;
    err_d                   = err_q;
    asm_clr                 = 1'b0;
    asm_vld                 = 1'b0;
    asm_store               = 1'b0;
    miss_stall              = 1'b0;
    mem_req_valid           = 1'b0;
    mem_req_addr            = 32'd0;
    mem_req_len             = 8'd0;
    do_update_line          = 1'b0;
    do_update_tag_and_valid = 1'b0;
    refill_done             = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        miss_stall = miss;
        if (miss) begin
          miss_addr_d = line_base(query_addr, LINE_SIZE);
          state_d     = S_REQ;
        end
      end
      S_REQ: begin
        miss_stall    = 1'b1;
        mem_req_valid = 1'b1;
        mem_req_addr  = miss_addr_q;
        mem_req_len   = 8'(NBEATS - 1);
        if (mem_req_ready) begin
          asm_clr = 1'b1;
          state_d = flush ? S_DRAIN : S_FILL;
        end else if (flush) begin
          state_d = S_IDLE;
        end
      end
      S_FILL: begin
        miss_stall = 1'b1;
        if (mem_rvalid) begin
          asm_vld   = 1'b1;
          asm_store = 1'b1;
          if (mem_rlast != asm_last) err_d = 1'b1;
          // Counter, not rlast, decides where the line ends.
          if (asm_last)   state_d = flush ? S_IDLE : S_UPDATE;
          else if (flush) state_d = S_DRAIN;
        end else if (flush) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        miss_stall = 1'b1;
        if (mem_rvalid) begin
          asm_vld = 1'b1;
          if (mem_rlast != asm_last) err_d = 1'b1;
          if (asm_last) state_d = S_IDLE;
        end
      end
      S_UPDATE: begin
        miss_stall              = 1'b1;
        do_update_line          = ~flush;
        do_update_tag_and_valid = ~flush;
        refill_done             = ~flush;
        if (!flush) rr_d = rr_q + 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      miss_addr_q <= 32'd0;
      rr_q        <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      rr_q        <= rr_d;
      err_q       <= err_d;
    end
  end

  icache_line_assembler #(
    .MEM_WIDTH (MEM_WIDTH),
    .NBEATS    (NBEATS),
    .CNT_W     (CNT_W)
  ) u_asm (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (asm_clr),
    .beat_vld_i (asm_vld),
    .store_i    (asm_store),
    .beat_dat_i (mem_rdata),
    .cnt_o      (asm_cnt),
    .last_o     (asm_last),
    .line_o     (update_line_data)
  );

  // Address, way and line are held registers; only the strobes qualify them.
  assign update_addr      = miss_addr_q;
  assign update_way       = rr_q;
  assign refill_err       = err_q;
  assign do_clear_dirty   = 1'b0;
  assign update_dirty_bit = 1'b0;

endmodule

// File: tb/tb_icache_refill_controller.sv
// Directed bench for the refill controller; expected installs are queued at miss time
// and checked by a monitor when the update strobes fire.
module tb_icache_refill_controller;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         query_valid;
  logic [31:0]  query_addr;
  logic         query_hit;
  logic         miss_stall;
  logic         mem_req_valid;
  logic         mem_req_ready;
  logic [31:0]  mem_req_addr;
  logic [7:0]   mem_req_len;
  logic         mem_rvalid;
  logic [63:0]  mem_rdata;
  logic         mem_rlast;
  logic         do_update_line;
  logic         do_update_tag_and_valid;
  logic         do_clear_dirty;
  logic [31:0]  update_addr;
  logic [511:0] update_line_data;
  logic [2:0]   update_way;
  logic         update_dirty_bit;
  logic         refill_done;
  logic         refill_err;

  icache_refill_controller #(
    .LINE_SIZE (64),
    .WAYS      (8),
    .MEM_WIDTH (64)
  ) dut (
    .clk                     (clk),
    .rst                     (rst),
    .flush                   (flush),
    .query_valid             (query_valid),
    .query_addr              (query_addr),
    .query_hit               (query_hit),
    .miss_stall              (miss_stall),
    .mem_req_valid           (mem_req_valid),
    .mem_req_ready           (mem_req_ready),
    .mem_req_addr            (mem_req_addr),
    .mem_req_len             (mem_req_len),
    .mem_rvalid              (mem_rvalid),
    .mem_rdata               (mem_rdata),
    .mem_rlast               (mem_rlast),
    .do_update_line          (do_update_line),
    .do_update_tag_and_valid (do_update_tag_and_valid),
    .do_clear_dirty          (do_clear_dirty),
    .update_addr             (update_addr),
    .update_line_data        (update_line_data),
    .update_way              (update_way),
    .update_dirty_bit        (update_dirty_bit),
    .refill_done             (refill_done),
    .refill_err              (refill_err)
  );

  typedef struct {
    logic [31:0]  addr;
    logic [2:0]   way;
    logic [511:0] line;
  } exp_t;

  exp_t sb_q[$];
  int   nvec = 0;
  int   nfail = 0;
  int   installs = 0;
  int   exp_installs = 0;
  logic [2:0] exp_way = 3'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, vectors=%0d", nvec);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [63:0] beat_val(input int tag, input int k);
    return {16'(tag), 16'(k), 32'hC0DE_0000 | 32'(k * 17)};
  endfunction

  function automatic logic [511:0] line_val(input int tag);
    logic [511:0] l;
    l = '0;
    for (int k = 0; k < 8; k++) l[k*64 +: 64] = beat_val(tag, k);
    return l;
  endfunction

  // Install monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && do_update_line) begin
      installs++;
      chk("install_expected", 512'(sb_q.size() > 0), 512'(1));
      chk("install_tag_valid", 512'(do_update_tag_and_valid), 512'(1));
      chk("install_done", 512'(refill_done), 512'(1));
      if (sb_q.size() > 0) begin
        exp_t e;
        e = sb_q.pop_front();
        chk("install_addr", 512'(update_addr), 512'(e.addr));
        chk("install_way", 512'(update_way), 512'(e.way));
        chk("install_line", update_line_data, e.line);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_install(input logic [31:0] base, input int tag);
    exp_t e;
    e.addr = base;
    e.way  = exp_way;
    e.line = line_val(tag);
    sb_q.push_back(e);
    exp_way = exp_way + 3'd1;
    exp_installs++;
  endtask

  // Miss in IDLE, hold ready low for wait_cyc cycles, then handshake; returns in FILL.
  task automatic start_refill(input logic [31:0] addr, input int wait_cyc);
    logic [31:0] base;
    base = addr & 32'hFFFF_FFC0;
    query_valid = 1'b1;
    query_addr  = addr;
    query_hit   = 1'b0;
    #1;
    chk("miss_stall_idle", 512'(miss_stall), 512'(1));
    tick();
    query_valid = 1'b0;
    for (int w = 0; w < wait_cyc; w++) begin
      chk("req_valid_wait", 512'(mem_req_valid), 512'(1));
      chk("req_addr_wait", 512'(mem_req_addr), 512'(base));
      chk("req_len_wait", 512'(mem_req_len), 512'(7));
      tick();
    end
    mem_req_ready = 1'b1;
    #1;
    chk("req_valid", 512'(mem_req_valid), 512'(1));
    chk("req_addr", 512'(mem_req_addr), 512'(base));
    chk("req_len", 512'(mem_req_len), 512'(7));
    tick();
    mem_req_ready = 1'b0;
  endtask

  task automatic send_beats(input int tag, input int from, input int to, input int gap, input int last_at);
    for (int k = from; k <= to; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = beat_val(tag, k);
      mem_rlast  = (k == last_at);
      tick();
      mem_rvalid = 1'b0;
      mem_rlast  = 1'b0;
      if (k < to) repeat (gap) tick();
    end
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; query_valid = 1'b0; query_addr = '0; query_hit = 1'b0;
    mem_req_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_rlast = 1'b0;
    #3;
    chk("rst_miss_stall", 512'(miss_stall), 512'(0));
    chk("rst_req_valid", 512'(mem_req_valid), 512'(0));
    chk("rst_req_len", 512'(mem_req_len), 512'(0));
    chk("rst_update_way", 512'(update_way), 512'(0));
    chk("rst_line", update_line_data, 512'(0));
    chk("rst_err", 512'(refill_err), 512'(0));
    repeat (2) tick();
    rst = 1'b1;
    tick();

    // Single miss, minimum latency: UPDATE lands 10 cycles after the miss.
    start_refill(32'h0000_1234, 0);
    expect_install(32'h0000_1200, 1);
    send_beats(1, 0, 7, 0, 7);
    chk("t1_update_cycle", 512'(do_update_line), 512'(1));
    chk("t1_line_lo", 512'(update_line_data[63:0]), 512'(beat_val(1, 0)));
    chk("t1_line_hi", 512'(update_line_data[511:448]), 512'(beat_val(1, 7)));
    tick();
    chk("t1_strobe_off", 512'(do_update_line), 512'(0));
    chk("t1_done_off", 512'(refill_done), 512'(0));
    query_valid = 1'b1; query_hit = 1'b1;
    #1;
    chk("t1_retry_hit", 512'(miss_stall), 512'(0));
    query_valid = 1'b0; query_hit = 1'b0;
    chk("t1_installs", 512'(installs), 512'(exp_installs));

    // Request backpressure and gapped beats.
    start_refill(32'h0000_8F7C, 3);
    expect_install(32'h0000_8F40, 2);
    send_beats(2, 0, 7, 1, 7);
    tick();
    chk("t2_installs", 512'(installs), 512'(exp_installs));

    // Consecutive misses walk the round-robin pointer through the wrap.
    for (int i = 0; i < 7; i++) begin
      start_refill(32'h0001_0004 + 32'(i * 64), 0);
      expect_install(32'h0001_0000 + 32'(i * 64), 10 + i);
      send_beats(10 + i, 0, 7, 0, 7);
      tick();
    end
    chk("t3_rr_wrap", 512'(update_way), 512'(exp_way));
    chk("t3_installs", 512'(installs), 512'(exp_installs));

    // Flush on beat 3: remaining beats drained, nothing installed.
    start_refill(32'h2000_0048, 0);
    send_beats(20, 0, 2, 0, 7);
    flush = 1'b1; mem_rvalid = 1'b1; mem_rdata = beat_val(20, 3);
    tick();
    flush = 1'b0; mem_rvalid = 1'b0;
    chk("t4_drain_stall", 512'(miss_stall), 512'(1));
    send_beats(20, 4, 7, 0, 7);
    chk("t4_idle_stall", 512'(miss_stall), 512'(0));
    chk("t4_no_update", 512'(do_update_line), 512'(0));
    tick();
    chk("t4_rr_kept", 512'(update_way), 512'(exp_way));
    chk("t4_installs", 512'(installs), 512'(exp_installs));

    // Flush coincident with UPDATE suppresses the install.
    start_refill(32'h2000_1000, 0);
    send_beats(21, 0, 7, 0, 7);
    flush = 1'b1;
    #1;
    chk("t5_upd_line_off", 512'(do_update_line), 512'(0));
    chk("t5_upd_tag_off", 512'(do_update_tag_and_valid), 512'(0));
    chk("t5_done_off", 512'(refill_done), 512'(0));
    tick();
    flush = 1'b0;
    chk("t5_rr_kept", 512'(update_way), 512'(exp_way));
    chk("t5_installs", 512'(installs), 512'(exp_installs));

    // Flush in REQ without ready returns to IDLE.
    query_valid = 1'b1; query_addr = 32'h2000_2000;
    tick();
    query_valid = 1'b0; flush = 1'b1;
    #1;
    chk("t5b_req_valid", 512'(mem_req_valid), 512'(1));
    tick();
    flush = 1'b0;
    #1;
    chk("t5b_idle_req", 512'(mem_req_valid), 512'(0));
    chk("t5b_idle_stall", 512'(miss_stall), 512'(0));

    // Flush together with the handshake: the whole burst is drained.
    query_valid = 1'b1; query_addr = 32'h2000_3000;
    tick();
    query_valid = 1'b0; flush = 1'b1; mem_req_ready = 1'b1;
    tick();
    flush = 1'b0; mem_req_ready = 1'b0;
    chk("t5c_drain_stall", 512'(miss_stall), 512'(1));
    send_beats(22, 0, 7, 0, 7);
    chk("t5c_idle_stall", 512'(miss_stall), 512'(0));
    tick();
    chk("t5c_installs", 512'(installs), 512'(exp_installs));

    // Early rlast flags a sticky error, refill still completes by count.
    start_refill(32'h4000_0080, 0);
    expect_install(32'h4000_0080, 30);
    send_beats(30, 0, 4, 0, 5);
    chk("t6_err_before", 512'(refill_err), 512'(0));
    send_beats(30, 5, 7, 0, 5);
    chk("t6_err_set", 512'(refill_err), 512'(1));
    repeat (2) tick();
    chk("t6_err_sticky", 512'(refill_err), 512'(1));
    chk("t6_installs", 512'(installs), 512'(exp_installs));

    // Asynchronous reset in the middle of FILL.
    start_refill(32'h3000_0000, 0);
    send_beats(40, 0, 3, 0, 7);
    rst = 1'b0;
    #1;
    chk("t7_stall", 512'(miss_stall), 512'(0));
    chk("t7_req_valid", 512'(mem_req_valid), 512'(0));
    chk("t7_err", 512'(refill_err), 512'(0));
    chk("t7_line", update_line_data, 512'(0));
    chk("t7_way", 512'(update_way), 512'(0));
    chk("t7_addr", 512'(update_addr), 512'(0));
    tick();
    rst = 1'b1;
    exp_way = 3'd0;
    tick();
    start_refill(32'h3000_0140, 0);
    expect_install(32'h3000_0140, 41);
    send_beats(41, 0, 7, 0, 7);
    tick();
    chk("t7_post_installs", 512'(installs), 512'(exp_installs));
    chk("sb_drained", 512'(sb_q.size()), 512'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/icache_refill_controller.md
Name: icache_refill_controller

Overview:
Miss handler and refill engine for the instruction cache core. It detects query misses, stalls fetch, and issues a line-aligned burst read to the next memory level. It assembles the returned beats into a full line and drives the cache's refill/update port (line, tag/valid, way) to install it. The iCache is read-only: no dirty lines and no victim writeback.

Parameters:
LINE_SIZE, 64, cache line size in bytes (power of 2)
WAYS, 8, associativity (power of 2)
MEM_WIDTH, 64, memory read data width in bits; BEATS = LINE_SIZE*8/MEM_WIDTH (≥2)

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-low
flush  in  1  cache flush / refill abort
query_valid  in  1  fetch query active
query_addr  in  32  fetch address
query_hit  in  1  hit result from cache core, same cycle as query
miss_stall  out  1  fetch must hold query_addr and retry
mem_req_valid  out  1  burst read request valid
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  32  line base address = query_addr & ~(LINE_SIZE-1)
mem_req_len  out  8  BEATS-1
mem_rvalid  in  1  read beat valid (no backpressure)
mem_rdata  in  MEM_WIDTH  read beat data
mem_rlast  in  1  final beat marker
do_update_line  out  1  write update_line_data into update_way
do_update_tag_and_valid  out  1  write tag, set valid
do_clear_dirty  out  1  constant 0
update_addr  out  32  line base address of refill
update_line_data  out  LINE_SIZE*8  assembled line
update_way  out  log2(WAYS)  victim way
update_dirty_bit  out  1  constant 0
refill_done  out  1  one-cycle pulse on line install
refill_err  out  1  sticky protocol-error flag

Behaviour:
- Reset (rst=0, async): state IDLE, all outputs 0, beat counter 0, round-robin way pointer 0, refill_err 0, line buffer 0.
- FSM states: IDLE, REQ, FILL, UPDATE, DRAIN.
- IDLE: a miss is query_valid & !query_hit & !flush. A miss latches the line base into miss_addr and goes to REQ next cycle. Outputs while in IDLE: miss_stall = the miss term (combinational).
- REQ: mem_req_valid=1, mem_req_addr=miss_addr, mem_req_len=BEATS-1, held stable until mem_req_ready. On handshake go to FILL with beat counter 0. If flush is high and there is no handshake that cycle, go to IDLE. If flush and handshake coincide, go to DRAIN.
- FILL: on each mem_rvalid, write mem_rdata into buffer bits [cnt*MEM_WIDTH +: MEM_WIDTH] and increment cnt. The beat with cnt==BEATS-1 moves to UPDATE next cycle. cnt is authoritative. If mem_rlast != (cnt==BEATS-1) on any valid beat, set refill_err (sticky until reset). If flush is seen in FILL, go to DRAIN.
- DRAIN: consume the remaining beats until cnt reaches BEATS-1, then go to IDLE. There is no update in DRAIN.
- UPDATE (exactly 1 cycle): do_update_line = do_update_tag_and_valid = refill_done = !flush. update_addr = miss_addr, update_way = rr_ptr. rr_ptr increments modulo WAYS only if the update was issued (wraps 7→0). Next state is IDLE.
- miss_stall is 1 in REQ, FILL, DRAIN and UPDATE. The cycle after UPDATE is IDLE, where the retried query hits.
- Miss-to-install latency = 2 + request wait + beat arrival cycles. Minimum with ready=1 and back-to-back beats: miss at N, req at N+1, beats N+2..N+1+BEATS, UPDATE at N+2+BEATS.
- update_line_data and update_addr hold their value outside UPDATE. Consumers qualify them only by the strobes.
- Misses arriving outside IDLE are ignored; fetch is stalled, so none arrive legally.

Decomposition:
- Package icache_pkg: FSM state enum; localparams BEATS, BEAT_CNT_W = log2(BEATS), OFFSET_W = log2(LINE_SIZE), WAY_W = log2(WAYS); line-base mask function.
- One sub-module, icache_line_assembler: beat counter plus indexed line buffer, with clear/write/last outputs. The FSM stays in the top module.

Test Plan:
- Single miss, query_addr=0x0000_1234, ready=1, 8 back-to-back beats D0..D7 → mem_req_addr=0x0000_1200, len=7. UPDATE at miss+10 with update_addr=0x1200, update_way=0, line[63:0]=D0, line[511:448]=D7, refill_done pulse.
- Request backpressure: ready low for 3 cycles, beats gapped by 1 idle cycle → mem_req_addr/len stable while waiting. Install occurs exactly once, with correct data.
- Eight consecutive misses → update_way sequence 0,1,...,7. Ninth miss → way 0 (wrap).
- Flush at beat 3 of FILL → DRAIN consumes beats 4..7. No do_update_* pulse, rr_ptr unchanged, back in IDLE.
- Flush coincident with UPDATE → strobes stay 0, rr_ptr unchanged. Flush in REQ without ready → IDLE, no request accepted.
- mem_rlast asserted on beat 5 → refill_err=1 and stays set. Refill still completes after beat 7. Async rst mid-FILL → all outputs 0 immediately, refill_err cleared.
